// File: rtl/adc_frame_align.sv
// adc_frame_align: bitslip sequencer for the 2-lane DDR ADC receiver.
// Watches the deserialised frame word, issues single-cycle bitslip pulses
// until the frame pattern is seen MATCHN times in a row, then supervises lock.
// Optional feature macro: ADC_FRAME_ALIGN_RELOCK_EN (automatic relock on loss).
// All outputs are registered from the next-state decision, so they change on
// the same edge as the state register.
module adc_frame_align #(
  parameter logic [5:0] FRAME   = 6'b000111,
  parameter int         SETTLE  = 15,
  parameter int         MATCHN  = 16,
  parameter int         MAXSLIP = 12,
  parameter int         LOSSN   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [5:0] i_fr,
  output logic       o_bs,
  output logic       o_locked,
  output logic       o_fail,
  output logic       o_loss,
  output logic [3:0] o_slips,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_SLIP   = 3'd3,
    S_LOCK   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [7:0] C_SETTLE     = 8'(SETTLE);
  localparam logic [7:0] C_MATCH_LAST = 8'(MATCHN - 1);
  localparam logic [7:0] C_LOSS_LAST  = 8'(LOSSN - 1);
  localparam logic [3:0] C_MAXSLIP    = 4'(MAXSLIP);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait;
  logic [7:0] r_match;
  logic [7:0] r_loss;
  logic       r_bs;
  logic       r_locked;
  logic       r_fail;
  logic       r_loss_flag;
  logic [3:0] r_slips;

  logic       w_match;
  logic       w_loss_evt;
  logic       w_restore;

  assign w_match = (i_fr == FRAME);

  // Re-acquire after a loss without bitslipping: only used while unlocked in LOCK
  assign w_restore = (r_state == S_LOCK) && !r_locked && w_match &&
                     (r_match == C_MATCH_LAST);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decision; ENABLE low overrides everything
  always_comb begin
    w_next     = r_state;
    w_loss_evt = 1'b0;
    if (!i_enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_SETTLE;
        S_SETTLE: if (r_wait == 8'd0) w_next = S_CHECK;
        S_CHECK: begin
          if (w_match) begin
            if (r_match == C_MATCH_LAST) w_next = S_LOCK;
          end else if (r_slips == C_MAXSLIP) begin
            w_next = S_FAIL;
          end else begin
            w_next = S_SLIP;
          end
        end
        S_SLIP:   w_next = S_SETTLE;
        S_LOCK: begin
          if (r_locked && !w_match && (r_loss == C_LOSS_LAST)) begin
            w_loss_evt = 1'b1;
`ifdef ADC_FRAME_ALIGN_RELOCK_EN
            w_next = S_SLIP;
`else
            w_next = S_LOCK;
`endif
          end
        end
        S_FAIL:   w_next = S_FAIL;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Counters and registered outputs, all derived from the upcoming state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait      <= '0;
      r_match     <= '0;
      r_loss      <= '0;
      r_bs        <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
      r_loss_flag <= 1'b0;
      r_slips     <= '0;
    end else begin
      r_bs   <= (w_next == S_SLIP);
      r_fail <= (w_next == S_FAIL);

      // Settle wait: loaded on entry, counts down while staying (never below 0)
      if (w_next == S_SETTLE)
        r_wait <= (r_state == S_SETTLE) ? r_wait - 8'd1 : C_SETTLE;
      else
        r_wait <= '0;

      // Consecutive-match run: in CHECK, and in LOCK while waiting to restore
      if (w_next == S_CHECK)
        r_match <= (r_state == S_CHECK) ? r_match + 8'd1 : 8'd0;
      else if ((w_next == S_LOCK) && (r_state == S_LOCK) && !r_locked &&
               w_match && !w_restore)
        r_match <= r_match + 8'd1;
      else
        r_match <= '0;

      // Consecutive-mismatch run while locked; cleared by any match
      if ((w_next == S_LOCK) && (r_state == S_LOCK) && r_locked &&
          !w_match && !w_loss_evt)
        r_loss <= r_loss + 8'd1;
      else
        r_loss <= '0;

      if (w_next != S_LOCK)       r_locked <= 1'b0;
      else if (r_state != S_LOCK) r_locked <= 1'b1;
      else if (w_loss_evt)        r_locked <= 1'b0;
      else if (w_restore)         r_locked <= 1'b1;

      // Sticky loss indication, only IDLE clears it
      if (w_next == S_IDLE)  r_loss_flag <= 1'b0;
      else if (w_loss_evt)   r_loss_flag <= 1'b1;

      // Slip count: a relock from LOCK starts a fresh search with this pulse
      if (w_next == S_IDLE)
        r_slips <= '0;
      else if (w_next == S_SLIP) begin
        if (r_state == S_LOCK)     r_slips <= 4'd1;
        else if (r_slips != 4'hF)  r_slips <= r_slips + 4'd1;
      end
    end
  end

  assign o_bs     = r_bs;
  assign o_locked = r_locked;
  assign o_fail   = r_fail;
  assign o_loss   = r_loss_flag;
  assign o_slips  = r_slips;
  assign o_state  = r_state;

endmodule

// File: tb/tb_adc_frame_align.sv
// Scoreboard bench for adc_frame_align. A receiver model rotates the frame word
// by one bit per bitslip pulse; stimulus pushes the events it expects (pulses,
// lock/unlock, fail, loss) and a negedge monitor pops and compares them.
module tb_adc_frame_align;
  localparam logic [5:0] FRAME   = 6'b000111;
  localparam int         SETTLE  = 15;
  localparam int         MATCHN  = 16;
  localparam int         MAXSLIP = 12;
  localparam int         LOSSN   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_enable = 1'b0;
  logic [5:0] i_fr = FRAME;
  logic       o_bs, o_locked, o_fail, o_loss;
  logic [3:0] o_slips;
  logic [2:0] o_state;

  adc_frame_align #(.FRAME(FRAME), .SETTLE(SETTLE), .MATCHN(MATCHN),
                    .MAXSLIP(MAXSLIP), .LOSSN(LOSSN)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(i_enable), .i_fr(i_fr),
    .o_bs(o_bs), .o_locked(o_locked), .o_fail(o_fail), .o_loss(o_loss),
    .o_slips(o_slips), .o_state(o_state)
  );

  initial forever #5 clk = ~clk;

  typedef enum int {EV_BS, EV_LOCK, EV_UNLOCK, EV_FAIL, EV_LOSS} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       slips;  // -1: don't care
    int       t;      // -1: don't care, else exact cycle
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  // Receiver model state
  int  off   = 0;
  bit  stuck = 1'b0;

  initial forever @(posedge clk) cyc++;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [5:0] rot(input int n);
    logic [5:0] r;
    r = FRAME;
    for (int j = 0; j < n; j++) r = {r[4:0], r[5]};
    return r;
  endfunction

  function automatic void push(ev_kind_t k, int slips, int t);
    ev_t e;
    e.kind = k; e.slips = slips; e.t = t;
    exp_q.push_back(e);
  endfunction

  function automatic void pop_expect(ev_kind_t k, string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: got event with empty queue (cycle %0d)", name, cyc);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, int'(k), int'(e.kind));
      if (e.slips >= 0) check({name, "_slips"}, int'(o_slips), e.slips);
      if (e.t >= 0)     check({name, "_time"}, cyc, e.t);
    end
  endfunction

  // Monitor: every observable event must match the head of the queue
  initial begin
    bit p_locked, p_fail, p_loss;
    int last_bs;
    p_locked = 0; p_fail = 0; p_loss = 0; last_bs = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_loss && !p_loss)     pop_expect(EV_LOSS, "loss");
        if (!o_locked && p_locked) pop_expect(EV_UNLOCK, "unlock");
        if (o_bs) begin
          pop_expect(EV_BS, "bs");
          if (last_bs >= 0) check("bs_spacing_ok", int'((cyc - last_bs) >= SETTLE + 2), 1);
          last_bs = cyc;
        end
        if (o_locked && !p_locked) pop_expect(EV_LOCK, "lock");
        if (o_fail && !p_fail)     pop_expect(EV_FAIL, "fail");
      end
      p_locked = o_locked; p_fail = o_fail; p_loss = o_loss;
    end
  end

  // One cycle of the receiver model: a bitslip rotates the word by one position
  task automatic step(input bit bad);
    @(negedge clk);
    if (o_bs) off = (off + 5) % 6;
    if (stuck)    i_fr = 6'b101010;
    else if (bad) i_fr = FRAME ^ 6'($urandom_range(1, 63));
    else          i_fr = rot(off);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b0);
    step(1'b0);
    if (exp_q.size() != 0) begin
      check("timeout_events_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic start(input int o, output int en_cyc);
    off = o;
    i_fr = stuck ? 6'b101010 : rot(off);
    i_enable = 1'b1;
    en_cyc = cyc;
  endtask

  task automatic disable_to_idle(input bit was_locked);
    if (was_locked) push(EV_UNLOCK, -1, -1);
    i_enable = 1'b0;
    step(1'b0);
    step(1'b0);
    check("idle_state", int'(o_state), 0);
  endtask

  initial begin
    int en_cyc, k, n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bs", int'(o_bs), 0);
    check("rst_state", int'(o_state), 0);
    rst = 1'b0;
    step(1'b0);
    step(1'b0);
    check("init_bs", int'(o_bs), 0);
    check("init_locked", int'(o_locked), 0);
    check("init_fail", int'(o_fail), 0);
    check("init_loss", int'(o_loss), 0);
    check("init_slips", int'(o_slips), 0);
    check("init_state", int'(o_state), 0);

    // Already aligned: no pulses, lock at a fixed latency
    start(0, en_cyc);
    push(EV_LOCK, 0, en_cyc + SETTLE + MATCHN + 2);
    wait_empty(100);
    check("aligned_locked", int'(o_locked), 1);
    disable_to_idle(1'b1);

    // Random offsets, short glitches, then a real loss of lock
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) push(EV_BS, -1, -1);
      push(EV_LOCK, k, -1);
      start(k, en_cyc);
      wait_empty(k * (SETTLE + 3) + MATCHN + 40);
      check("search_slips", int'(o_slips), k);

      n = $urandom_range(1, LOSSN - 1);
      for (int j = 0; j < n; j++) step(1'b1);
      repeat (10) step(1'b0);
      check("glitch_locked", int'(o_locked), 1);
      check("glitch_loss", int'(o_loss), 0);

      push(EV_LOSS, -1, -1);
      push(EV_UNLOCK, -1, -1);
`ifdef ADC_FRAME_ALIGN_RELOCK_EN
      // Loss pulse moves the receiver to offset 5: five more pulses to realign
      for (int j = 0; j < 6; j++) push(EV_BS, -1, -1);
      push(EV_LOCK, 6, -1);
`else
      push(EV_LOCK, k, -1);
`endif
      for (int j = 0; j < LOSSN; j++) step(1'b1);
      wait_empty(6 * (SETTLE + 3) + MATCHN + 40);
      check("loss_sticky", int'(o_loss), 1);
      check("relocked", int'(o_locked), 1);
      disable_to_idle(1'b1);
      check("idle_loss_clr", int'(o_loss), 0);
    end

    // Stuck frame word: MAXSLIP pulses then FAIL and silence
    stuck = 1'b1;
    for (int j = 0; j < MAXSLIP; j++) push(EV_BS, -1, -1);
    push(EV_FAIL, MAXSLIP, -1);
    start(0, en_cyc);
    wait_empty(MAXSLIP * (SETTLE + 3) + 40);
    repeat (40) step(1'b0);
    check("fail_held", int'(o_fail), 1);
    check("fail_state", int'(o_state), 5);
    disable_to_idle(1'b0);
    check("fail_cleared", int'(o_fail), 0);
    stuck = 1'b0;

    // Asynchronous reset in the middle of a settle wait after two slips
    push(EV_BS, -1, -1);
    push(EV_BS, -1, -1);
    start(3, en_cyc);
    wait_empty(3 * (SETTLE + 3) + 10);
    repeat (3) step(1'b0);
    check("pre_rst_state", int'(o_state), 1);
    check("pre_rst_slips", int'(o_slips), 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", int'(o_state), 0);
    check("async_rst_slips", int'(o_slips), 0);
    check("async_rst_bs", int'(o_bs), 0);
    i_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0);

    // Abort during the bitslip cycle
    push(EV_BS, -1, -1);
    start(4, en_cyc);
    for (int i = 0; i < 60; i++) begin
      step(1'b0);
      if (o_bs) break;
    end
    i_enable = 1'b0;
    step(1'b0);
    check("abort_slip_state", int'(o_state), 0);
    check("abort_slip_slips", int'(o_slips), 0);
    repeat (40) step(1'b0);

    // Abort during the settle wait
    push(EV_BS, -1, -1);
    start(4, en_cyc);
    for (int i = 0; i < 60; i++) begin
      step(1'b0);
      if (o_bs) break;
    end
    repeat (5) step(1'b0);
    check("abort_settle_pre", int'(o_state), 1);
    i_enable = 1'b0;
    step(1'b0);
    check("abort_settle_state", int'(o_state), 0);
    repeat (40) step(1'b0);

    check("events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
